// File: rtl/ifft8_pkg.sv
// rtl/ifft8_pkg.sv - shared constants, state type and helpers for the 8-point inverse FFT
package ifft8_pkg;

    localparam int W_DEF       = 16;
    localparam int TW_FRAC_DEF = 14;

    // Conjugate twiddles W8^-k in Q1.14
    localparam int TW_RE [4] = '{16384, 11585, 0, -11585};
    localparam int TW_IM [4] = '{0, 11585, 16384, 11585};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/ifft8_bfly.sv
// rtl/ifft8_bfly.sv - combinational DIF butterfly with halving and saturation
module ifft8_bfly
    import ifft8_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF
) (
    input  logic signed [W-1:0]         a_re_i,
    input  logic signed [W-1:0]         a_im_i,
    input  logic signed [W-1:0]         b_re_i,
    input  logic signed [W-1:0]         b_im_i,
    input  logic signed [TW_FRAC+1:0]   tw_re_i,
    input  logic signed [TW_FRAC+1:0]   tw_im_i,
    output logic signed [W-1:0]         top_re_o,
    output logic signed [W-1:0]         top_im_o,
    output logic signed [W-1:0]         bot_re_o,
    output logic signed [W-1:0]         bot_im_o
);

    localparam int PW = 2 * W + 2;

    logic signed [W:0]    sum_re, sum_im, dif_re, dif_im;
    logic signed [PW-1:0] prod_re, prod_im;

    always_comb begin
        sum_re  = (W+1)'(a_re_i) + (W+1)'(b_re_i);
        sum_im  = (W+1)'(a_im_i) + (W+1)'(b_im_i);
        dif_re  = (W+1)'(a_re_i) - (W+1)'(b_re_i);
        dif_im  = (W+1)'(a_im_i) - (W+1)'(b_im_i);
        prod_re = PW'(dif_re) * PW'(tw_re_i) - PW'(dif_im) * PW'(tw_im_i);
        prod_im = PW'(dif_re) * PW'(tw_im_i) + PW'(dif_im) * PW'(tw_re_i);
        // The extra bit of shift on the product folds the per-stage 1/2 into the twiddle scaling
        top_re_o = W'(sat(64'(sum_re >>> 1), W));
        top_im_o = W'(sat(64'(sum_im >>> 1), W));
        bot_re_o = W'(sat(64'(prod_re >>> (TW_FRAC + 1)), W));
        bot_im_o = W'(sat(64'(prod_im >>> (TW_FRAC + 1)), W));
    end

endmodule

// File: rtl/ifft8_seq.sv
// rtl/ifft8_seq.sv - iterative 8-point radix-2 DIF inverse FFT, one butterfly per clock
module ifft8_seq
    import ifft8_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [8*W-1:0] din_re,
    input  logic [8*W-1:0] din_im,
    output logic           busy,
    output logic           done,
    output logic [8*W-1:0] dout_re,
    output logic [8*W-1:0] dout_im
);

    localparam int TWW = TW_FRAC + 2;

    state_e              state_q;
    logic [1:0]          stage_q, bf_q;
    logic signed [W-1:0] re_q [8];
    logic signed [W-1:0] im_q [8];
    logic                busy_q, done_q;
    logic [8*W-1:0]      dout_re_q, dout_im_q;

    logic [2:0]            pos_p, pos_q;
    logic [1:0]            tw_k;
    logic signed [TWW-1:0] tw_re, tw_im;
    logic signed [W-1:0]   top_re, top_im, bot_re, bot_im;

    always_comb begin
        pos_p = '0;
        pos_q = '0;
        tw_k  = '0;
        case (stage_q)
            2'd0: begin
                pos_p = {1'b0, bf_q};
                pos_q = {1'b1, bf_q};
                tw_k  = bf_q;
            end
            2'd1: begin
                pos_p = {bf_q[1], 1'b0, bf_q[0]};
                pos_q = {bf_q[1], 1'b1, bf_q[0]};
                tw_k  = {bf_q[0], 1'b0};
            end
            default: begin
                pos_p = {bf_q, 1'b0};
                pos_q = {bf_q, 1'b1};
                tw_k  = 2'd0;
            end
        endcase
        tw_re = TWW'(TW_RE[tw_k]);
        tw_im = TWW'(TW_IM[tw_k]);
    end

    ifft8_bfly #(.W(W), .TW_FRAC(TW_FRAC)) u_bfly (
        .a_re_i   (re_q[pos_p]),
        .a_im_i   (im_q[pos_p]),
        .b_re_i   (re_q[pos_q]),
        .b_im_i   (im_q[pos_q]),
        .tw_re_i  (tw_re),
        .tw_im_i  (tw_im),
        .top_re_o (top_re),
        .top_im_o (top_im),
        .bot_re_o (bot_re),
        .bot_im_o (bot_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            bf_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_re_q <= '0;
            dout_im_q <= '0;
            for (int i = 0; i < 8; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= start;
                    if (start) begin
                        for (int i = 0; i < 8; i++) begin
                            re_q[i] <= din_re[i*W +: W];
                            im_q[i] <= din_im[i*W +: W];
                        end
                        stage_q <= '0;
                        bf_q    <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    re_q[pos_p] <= top_re;
                    im_q[pos_p] <= top_im;
                    re_q[pos_q] <= bot_re;
                    im_q[pos_q] <= bot_im;
                    bf_q        <= bf_q + 2'd1;
                    if (bf_q == 2'd3) begin
                        if (stage_q == 2'd2) begin
                            stage_q <= '0;
                            state_q <= DONE;
                        end else begin
                            stage_q <= stage_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                    // In-place DIF leaves the result in bit-reversed positions
                    for (int n = 0; n < 8; n++) begin
                        dout_re_q[n*W +: W] <= re_q[bitrev3(3'(n))];
                        dout_im_q[n*W +: W] <= im_q[bitrev3(3'(n))];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dout_re = dout_re_q;
    assign dout_im = dout_im_q;

endmodule

// File: tb/tb_ifft8_seq.sv
// tb/tb_ifft8_seq.sv - self-checking bench for ifft8_seq against a fixed-point DIF reference
module tb_ifft8_seq;

    localparam int W = 16;
    localparam real PI = 3.14159265358979;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [8*W-1:0] din_re = '0;
    logic [8*W-1:0] din_im = '0;
    logic           busy, done;
    logic [8*W-1:0] dout_re, dout_im;

    ifft8_seq #(.W(W), .TW_FRAC(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .din_re  (din_re),
        .din_im  (din_im),
        .busy    (busy),
        .done    (done),
        .dout_re (dout_re),
        .dout_im (dout_im)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*W-1:0] re;
        logic [8*W-1:0] im;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s actual %0d required %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    function automatic longint smp(input logic [8*W-1:0] v, input int n);
        logic signed [W-1:0] t;
        t = v[n*W +: W];
        return longint'(t);
    endfunction

    function automatic logic [8*W-1:0] pack(input int v[8]);
        logic [8*W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*W +: W] = v[k][W-1:0];
        return r;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: textbook in-place DIF with span 4,2,1, conjugate twiddles from cos/sin
    function automatic void model(input logic [8*W-1:0] ire, input logic [8*W-1:0] iim,
                                  output logic [8*W-1:0] ore, output logic [8*W-1:0] oim);
        longint r[8];
        longint m[8];
        for (int k = 0; k < 8; k++) begin
            r[k] = smp(ire, k);
            m[k] = smp(iim, k);
        end
        for (int s = 0; s < 3; s++) begin
            int span;
            span = 4 >> s;
            for (int p = 0; p < 8; p++) begin
                if ((p & span) == 0) begin
                    int q, k;
                    longint twr, twi, dr, di;
                    q   = p + span;
                    k   = (p % span) << s;
                    twr = longint'($floor(16384.0 * $cos(PI * k / 4.0) + 0.5));
                    twi = longint'($floor(16384.0 * $sin(PI * k / 4.0) + 0.5));
                    dr  = r[p] - r[q];
                    di  = m[p] - m[q];
                    r[p] = clamp((r[p] + r[q]) >>> 1);
                    m[p] = clamp((m[p] + m[q]) >>> 1);
                    r[q] = clamp((dr * twr - di * twi) >>> 15);
                    m[q] = clamp((dr * twi + di * twr) >>> 15);
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            int br;
            br = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            ore[n*W +: W] = r[br][W-1:0];
            oim[n*W +: W] = m[br][W-1:0];
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                for (int n = 0; n < 8; n++) begin
                    chk($sformatf("model_re[%0d]", n), smp(dout_re, n), smp(e.re, n));
                    chk($sformatf("model_im[%0d]", n), smp(dout_im, n), smp(e.im, n));
                end
            end
        end
    end

    // Call at a negedge; the next posedge is the start edge
    task automatic launch(input logic [8*W-1:0] re, input logic [8*W-1:0] im);
        res_t r;
        din_re = re;
        din_im = im;
        start  = 1'b1;
        model(re, im, r.re, r.im);
        exp_q.push_back(r);
    endtask

    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (busy) nb++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_x(input string name, input int n, input longint er, input longint ei, input longint tol);
        chk_tol({name, $sformatf("_re[%0d]", n)}, smp(dout_re, n), er, tol);
        chk_tol({name, $sformatf("_im[%0d]", n)}, smp(dout_im, n), ei, tol);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int v_re[8];
        int v_im[8];
        int n, nb, dones;
        logic [8*W-1:0] a_re, a_im;

        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout_re_nonzero", longint'(|dout_re), 0);
        chk("rst_dout_im_nonzero", longint'(|dout_im), 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_in_reset_ignored", busy, 0);

        // DC bin
        v_re = '{8000, 0, 0, 0, 0, 0, 0, 0};
        v_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        launch(pack(v_re), pack(v_im));
        wait_done(n, nb);
        chk("dc_latency", n, 14);
        chk("dc_busy_cycles", nb, 14);
        for (int i = 0; i < 8; i++) chk_x("dc", i, 1000, 0, 0);
        @(negedge clk);
        chk("dc_done_one_cycle", done, 0);
        chk("dc_busy_low_after", busy, 0);

        // Flat spectrum
        v_re = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 8000};
        launch(pack(v_re), pack(v_im));
        wait_done(n, nb);
        chk_x("flat", 0, 8000, 0, 0);
        for (int i = 1; i < 8; i++) chk_x("flat", i, 0, 0, 0);
        @(negedge clk);

        // Single tone at bin 1
        v_re = '{0, 8192, 0, 0, 0, 0, 0, 0};
        launch(pack(v_re), pack(v_im));
        wait_done(n, nb);
        chk_x("tone", 0, 1024, 0, 1);
        chk_x("tone", 1, 724, 724, 1);
        chk_x("tone", 2, 0, 1024, 1);
        chk_x("tone", 3, -724, 724, 1);
        chk_x("tone", 4, -1024, 0, 1);
        chk_x("tone", 5, -724, -724, 1);
        chk_x("tone", 6, 0, -1024, 1);
        chk_x("tone", 7, 724, -724, 1);
        @(negedge clk);

        // Extreme values: odd outputs near +/-8192, even near 0
        v_re = '{32767, 0, 0, 0, -32768, 0, 0, 0};
        v_im = '{-32768, 0, 0, 0, 32767, 0, 0, 0};
        launch(pack(v_re), pack(v_im));
        wait_done(n, nb);
        chk_x("sat", 0, -1, -1, 0);
        chk_x("sat", 1, 8191, -8192, 0);
        for (int i = 1; i < 8; i += 2) begin
            chk($sformatf("sat_sign_re_pos[%0d]", i), longint'(smp(dout_re, i) > 0), 1);
            chk($sformatf("sat_sign_im_neg[%0d]", i), longint'(smp(dout_im, i) < 0), 1);
        end
        @(negedge clk);

        // Starts while busy are ignored; start in the done cycle is accepted
        a_re = {$urandom, $urandom, $urandom, $urandom};
        a_im = {$urandom, $urandom, $urandom, $urandom};
        launch(a_re, a_im);
        n = 0;
        dones = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n == 3 || n == 7 || n == 13) begin
                din_re = {$urandom, $urandom, $urandom, $urandom};
                din_im = {$urandom, $urandom, $urandom, $urandom};
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("ignore_latency", n, 14);
        launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        wait_done(n, nb);
        chk("back_to_back_latency", n, 14);
        @(negedge clk);

        // Reset during stage 1 aborts
        launch({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        repeat (7) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dout_re_nonzero", longint'(|dout_re), 0);
        chk("abort_dout_im_nonzero", longint'(|dout_im), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        v_re = '{8000, 0, 0, 0, 0, 0, 0, 0};
        v_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        launch(pack(v_re), pack(v_im));
        wait_done(n, nb);
        for (int i = 0; i < 8; i++) chk_x("dc_after_abort", i, 1000, 0, 0);
        @(negedge clk);

        // Random spectra, full range and moderate range, random gaps
        for (int t = 0; t < 30; t++) begin
            if (t % 2 == 0) begin
                a_re = {$urandom, $urandom, $urandom, $urandom};
                a_im = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                for (int k = 0; k < 8; k++) begin
                    v_re[k] = int'($urandom_range(8000)) - 4000;
                    v_im[k] = int'($urandom_range(8000)) - 4000;
                end
                a_re = pack(v_re);
                a_im = pack(v_im);
            end
            launch(a_re, a_im);
            wait_done(n, nb);
            chk("rand_latency", n, 14);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        @(negedge clk);
        chk("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
